uart_rx_device: RTL and testbench
=================================

// Module: uart_rx_device
// PURPOSE
// - Memory-mapped UART receiver: the receive counterpart to the system's transmit-only UART.
// - Sits as one device on the system bus. Converts serial 8N1 frames on uart_rx_i into bytes.
// - Buffers the bytes in a FIFO and raises a level interrupt for the core.
// PARAMETERS
// ClockFrequency  50_000_000  system clock in Hz
// BaudRate        115_200     serial rate; ClksPerBit = ClockFrequency/BaudRate (integer divide; 434 at defaults)
// RxFifoDepth     8           FIFO entries; power of two, >= 2
// PORTS
// clk_i            in   1   system clock; single clock domain
// rst_i            in   1   synchronous, active-high reset
// device_req_i     in   1   bus request; granted the same cycle
// device_addr_i    in   32  byte address; decode uses [3:2] only
// device_we_i      in   1   1 = write
// device_be_i      in   4   byte enables; ignored, full-word access
// device_wdata_i   in   32  write data
// device_rvalid_o  out  1   response valid, exactly 1 cycle after each req
// device_rdata_o   out  32  read data; registered
// uart_rx_i        in   1   asynchronous serial input; idles high
// irq_o            out  1   level interrupt
// BEHAVIOUR
// - Reset: device_rvalid_o=0, device_rdata_o=0, irq_o=0; FSM to IDLE; FIFO empty; all flags and irq_en cleared.
//   The 2-flop synchronizer resets to 1, so a reset mid-frame never produces a false start.
// - uart_rx_i passes through the 2-flop synchronizer. All sampling uses the synchronized value rx_s.
// - FSM: IDLE -> START -> DATA -> STOP -> IDLE. The baud counter reloads on every state change.
//   IDLE:  rx_s==0 -> START; counter counts ClksPerBit/2 (217 at defaults).
//   START: at expiry, rx_s==0 -> DATA. rx_s==1 (glitch) -> IDLE, nothing recorded.
//   DATA:  sample every ClksPerBit at mid-bit; 8 bits LSB first into a shift register; 3-bit bit counter; after bit 7 -> STOP.
//   STOP:  sample at mid-bit. rx_s==1 -> push byte. rx_s==0 -> set frame_err, discard byte.
//          Either way return to IDLE; a new start edge is accepted on the next cycle.
// - Register map, word offsets (all accesses answer rvalid 1 cycle later, reads and writes alike):
//   0x0 RXDATA  R: {24'b0, head byte}, pops FIFO. Empty -> reads 0, no pop. Write ignored.
//   0x4 STATUS  R: [0] not_empty, [1] full, [2] overflow, [3] frame_err, [8+:L] level with L=$clog2(RxFifoDepth)+1; others 0.
//               W: W1C on bits [2] and [3].
//   0x8 CTRL    RW: [0] irq_en. Others read 0.
//   0xC         reads 0; writes ignored.
// - Overflow: push while full and no pop that cycle -> byte dropped, overflow sticky set, FIFO contents unchanged.
// - Simultaneous push and pop:
//   - when full: pop first, push accepted, no overflow;
//   - when empty: read returns 0, pushed byte retained.
// - W1C clear in the same cycle as a new error event: set wins.
// - irq_o is a flop: irq_o <= irq_en & ~fifo_empty. It drops the cycle after the pop that empties the FIFO.
// STRUCTURE
// - uart_rx_pkg:
//   - register offsets RXDATA/STATUS/CTRL;
//   - STATUS bit indices;
//   - state enum rx_state_e {RxIdle, RxStart, RxData, RxStop}.
// - Sub-module uart_rx_fifo: synchronous FIFO, Width=8, Depth=RxFifoDepth.
//   - Pointers are one bit wider than the index, for full/empty detection.
//   - Outputs: level, full, empty.
// - Top holds the synchronizer, baud counter, FSM and register decode.
// TESTING (ClockFrequency=50 MHz, BaudRate=115200, RxFifoDepth=8)
// 1. Drive frame 0xA5 -> STATUS reads 0x0000_0101; RXDATA reads 0x0000_00A5; then STATUS reads 0x0.
// 2. uart_rx_i low for 100 clks, then high -> FSM back in IDLE; no byte; STATUS 0x0.
// 3. Frame 0x3C with stop bit low -> FIFO empty, STATUS=0x8. Write 0x8 to STATUS -> STATUS=0x0.
// 4. Nine back-to-back frames 0x01..0x09 -> STATUS=0x0000_0807; eight RXDATA reads return 0x01..0x08.
// 5. CTRL=1, receive 0x42 -> irq_o=1 one cycle after the stop sample. RXDATA read -> irq_o=0 next cycle.
// 6. rst_i pulsed during data bit 3 -> all outputs at reset values; next frame 0x5A received intact.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
// Holds the register word offsets (address bits [3:2]), the STATUS bit
// positions and the receive state machine encoding.
package uart_rx_pkg;

  // Word offsets, compared against device address bits [3:2].
  localparam logic [1:0] RegRxData = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;

  // STATUS bit positions. The FIFO level field starts at StatLevelLsb.
  localparam int unsigned StatNotEmpty = 0;
  localparam int unsigned StatFull     = 1;
  localparam int unsigned StatOverflow = 2;
  localparam int unsigned StatFrameErr = 3;
  localparam int unsigned StatLevelLsb = 8;

  // CTRL bit positions.
  localparam int unsigned CtrlIrqEn = 0;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// System bus device port.
//   req    : request, granted in the same cycle
//   addr   : byte address (device decodes [3:2] only)
//   we     : 1 = write
//   be     : byte enables (device treats every access as a full word)
//   wdata  : write data
//   rvalid : response valid, one cycle after each request
//   rdata  : registered read data
interface uart_rx_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, we, be, wdata, input rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output rvalid, rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes.
//   clk_i, rst_i : clock, synchronous active-high reset
//   wr_en/wr_data: push; accepted when not full, or when full and a pop
//                  happens the same cycle
//   rd_en        : pop; ignored while empty
//   rd_data      : head entry (valid while not empty)
//   level/full/empty : occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic [IdxW:0]    level,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [IdxW:0]    wr_ptr_q, rd_ptr_q;
  logic             do_rd, do_wr;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                 (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  assign rd_data = mem_q[rd_ptr_q[IdxW-1:0]];

  // A pop frees the head slot this cycle, so a push into a full FIFO fits.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[IdxW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_device.sv
// Memory-mapped UART receiver (8N1).
//   clk_i     : system clock
//   rst_i     : synchronous active-high reset
//   bus       : system bus device port (slave side)
//   uart_rx_i : asynchronous serial input, idles high
//   irq_o     : level interrupt, irq_en & FIFO not empty (registered)
// Registers (word offsets): 0x0 RXDATA (read pops), 0x4 STATUS (W1C on
// overflow/frame_err), 0x8 CTRL (irq_en), 0xC reads 0.
module uart_rx_device
  import uart_rx_pkg::*;
#(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned RxFifoDepth    = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  uart_rx_if.slave bus,
  input  logic     uart_rx_i,
  output logic     irq_o
);

  localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned LvlW       = $clog2(RxFifoDepth) + 1;

  localparam logic [CntW-1:0] HalfLoad = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(ClksPerBit - 1);

  // ---------------------------------------------------------------- sync
  // Resets to idle-high so a reset in the middle of a frame cannot be
  // mistaken for a start edge.
  logic rx_meta, rx_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) {rx_s, rx_meta} <= 2'b11;
    else       {rx_s, rx_meta} <= {rx_meta, uart_rx_i};
  end

  // ----------------------------------------------------------------- fsm
  rx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            cnt_done;

  assign cnt_done = (cnt_q == '0);

  // Counter reloads on every state change; each load is one less than the
  // interval because expiry is detected at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        RxIdle: begin
          if (!rx_s) begin
            state_q <= RxStart;
            cnt_q   <= HalfLoad;
          end
        end
        RxStart: begin
          if (cnt_done) begin
            if (!rx_s) begin
              state_q   <= RxData;
              cnt_q     <= FullLoad;
              bit_cnt_q <= '0;
            end else begin
              state_q <= RxIdle;  // line went high again: glitch
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RxData: begin
          if (cnt_done) begin
            shift_q   <= {rx_s, shift_q[7:1]};  // LSB first
            bit_cnt_q <= bit_cnt_q + 3'd1;
            cnt_q     <= FullLoad;
            if (bit_cnt_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RxStop: begin
          if (cnt_done) begin
            state_q <= RxIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  // Stop-bit outcome, decoded straight from state so the byte lands in the
  // FIFO on the sampling edge itself.
  logic stop_sample, push, frame_err_set;

  assign stop_sample   = (state_q == RxStop) && cnt_done;
  assign push          = stop_sample &  rx_s;
  assign frame_err_set = stop_sample & ~rx_s;

  // ---------------------------------------------------------------- fifo
  logic [7:0]      fifo_head;
  logic [LvlW-1:0] fifo_level;
  logic            fifo_full, fifo_empty;
  logic            pop;

  uart_rx_fifo #(
    .Width (8),
    .Depth (RxFifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ------------------------------------------------------------- regfile
  logic [1:0] reg_sel;
  logic       rd_req, wr_req;
  logic       overflow_set, overflow_clr, frame_err_clr;
  logic       overflow_q, frame_err_q, irq_en_q;
  logic       rvalid_q, irq_q;
  logic [31:0] rdata_q, status_word;

  assign reg_sel = bus.addr[3:2];
  assign rd_req  = bus.req & ~bus.we;
  assign wr_req  = bus.req &  bus.we;

  assign pop = rd_req && (reg_sel == RegRxData) && !fifo_empty;

  // A pop in the same cycle makes room, so only a blocked push overflows.
  assign overflow_set  = push && fifo_full && !pop;
  assign overflow_clr  = wr_req && (reg_sel == RegStatus) && bus.wdata[StatOverflow];
  assign frame_err_clr = wr_req && (reg_sel == RegStatus) && bus.wdata[StatFrameErr];

  always_comb begin
    status_word                          = '0;
    status_word[StatNotEmpty]            = ~fifo_empty;
    status_word[StatFull]                = fifo_full;
    status_word[StatOverflow]            = overflow_q;
    status_word[StatFrameErr]            = frame_err_q;
    status_word[StatLevelLsb +: LvlW]    = fifo_level;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rvalid_q <= bus.req;
      rdata_q  <= '0;
      if (rd_req) begin
        case (reg_sel)
          RegRxData: rdata_q <= fifo_empty ? 32'h0 : {24'h0, fifo_head};
          RegStatus: rdata_q <= status_word;
          RegCtrl:   rdata_q <= {31'h0, irq_en_q};
          default:   rdata_q <= '0;
        endcase
      end
      if (wr_req && (reg_sel == RegCtrl)) irq_en_q <= bus.wdata[CtrlIrqEn];
      // Set terms are OR'ed last so a new event beats a same-cycle clear.
      overflow_q  <= (overflow_q  & ~overflow_clr)  | overflow_set;
      frame_err_q <= (frame_err_q & ~frame_err_clr) | frame_err_set;
      irq_q       <= irq_en_q & ~fifo_empty;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign irq_o      = irq_q;

  // Address/data bits outside the decoded fields and the byte enables are
  // intentionally ignored.
  logic unused_bus;
  assign unused_bus = ^{bus.addr[31:4], bus.addr[1:0], bus.be,
                        bus.wdata[31:4], bus.wdata[1]};

endmodule

// File: tb/tb_uart_rx_device.sv
module tb_uart_rx_device;

  localparam int unsigned CLKS  = 50_000_000 / 115_200;  // 434
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic irq;

  uart_rx_if bus();

  uart_rx_device #(
    .ClockFrequency (50_000_000),
    .BaudRate       (115_200),
    .RxFifoDepth    (DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .uart_rx_i (rx),
    .irq_o     (irq)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: bytes the receiver should have buffered, oldest first.
  logic [7:0] sb_q [$];

  typedef struct {
    logic [7:0]  data;
    logic        stop_ok;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs [3];

  logic [31:0] d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic we, input logic [3:0] off, input logic [31:0] wd,
                        output logic [31:0] rd);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = {28'h0, off};
    bus.wdata = wd;
    @(negedge clk);
    bus.req = 1'b0;
    bus.we  = 1'b0;
    check("rvalid", {31'h0, bus.rvalid}, 32'h1);
    rd = bus.rdata;
  endtask

  task automatic read_check(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] r;
    bus_op(1'b0, off, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic write_reg(input logic [3:0] off, input logic [31:0] wd);
    logic [31:0] r;
    bus_op(1'b1, off, wd, r);
  endtask

  task automatic read_rxdata();
    logic [31:0] r, exp;
    bus_op(1'b0, 4'h0, 32'h0, r);
    exp = (sb_q.size() != 0) ? {24'h0, sb_q.pop_front()} : 32'h0;
    check("rxdata", r, exp);
  endtask

  task automatic drive_bit(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    if (sb_q.size() < DEPTH) sb_q.push_back(b);
  endtask

  // A bad stop bit is held low just past its mid-bit sample, then released,
  // so the receiver also sees (and rejects) a short false start.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0, CLKS);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CLKS);
    if (stop_ok) begin
      drive_bit(1'b1, CLKS);
      expect_byte(b);
    end else begin
      drive_bit(1'b0, CLKS / 2 + 40);
      drive_bit(1'b1, CLKS);
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, exp_status: 32'h0000_0101};
    vecs[1] = '{data: 8'h3C, stop_ok: 1'b0, exp_status: 32'h0000_0008};
    vecs[2] = '{data: 8'hC3, stop_ok: 1'b1, exp_status: 32'h0000_0101};

    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    bus.be    = 4'hF;
    bus.wdata = 32'h0;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    read_check("rst_status", 4'h4, 32'h0);
    read_check("rst_ctrl", 4'h8, 32'h0);

    // Register plumbing
    write_reg(4'h8, 32'hFFFF_FFFF);
    read_check("ctrl_rw", 4'h8, 32'h1);
    write_reg(4'h8, 32'h0);
    read_check("ctrl_clr", 4'h8, 32'h0);
    write_reg(4'hC, 32'hFFFF_FFFF);
    read_check("reg_c", 4'hC, 32'h0);
    read_rxdata();  // empty read returns 0

    // Single-frame table: good frames and a stop-bit error
    for (int v = 0; v < 3; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_ok);
      read_check("vec_status", 4'h4, vecs[v].exp_status);
      if (!vecs[v].stop_ok) begin
        write_reg(4'h4, 32'h8);
      end
      read_rxdata();
      read_check("vec_status_after", 4'h4, 32'h0);
      @(negedge clk);
      check("vec_irq_off", {31'h0, irq}, 32'h0);
    end

    // Start glitch: 100 clks low is far short of the half-bit check
    drive_bit(1'b0, 100);
    drive_bit(1'b1, CLKS);
    read_check("glitch_status", 4'h4, 32'h0);
    read_rxdata();

    // Nine back-to-back frames into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    read_check("ovf_status", 4'h4, 32'h0000_0807);
    for (int i = 0; i < 9; i++) read_rxdata();
    read_check("ovf_sticky", 4'h4, 32'h0000_0004);
    write_reg(4'h4, 32'h4);
    read_check("ovf_w1c", 4'h4, 32'h0);

    // Interrupt timing
    write_reg(4'h8, 32'h1);
    drive_bit(1'b0, CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[0] & 1'b0 | (8'h42 >> i) & 1'b1, CLKS);
    @(negedge clk);
    check("irq_before_stop", {31'h0, irq}, 32'h0);
    drive_bit(1'b1, CLKS);
    expect_byte(8'h42);
    @(negedge clk);
    check("irq_after_stop", {31'h0, irq}, 32'h1);
    bus_op(1'b0, 4'h0, 32'h0, d);
    check("irq_rxdata", d, 32'h0000_0042);
    void'(sb_q.pop_front());
    check("irq_hold", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check("irq_drop", {31'h0, irq}, 32'h0);

    // Reset in the middle of a frame (data bit 3), irq_en still set
    send_frame(8'h11, 1'b1);
    @(negedge clk);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    drive_bit(1'b0, CLKS);
    for (int i = 0; i < 3; i++) drive_bit((8'h08 >> i) & 1'b1, CLKS);
    drive_bit(1'b1, CLKS / 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    check("mid_rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
    check("mid_rst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    sb_q.delete();
    drive_bit(1'b1, 2 * CLKS);
    read_check("post_rst_status", 4'h4, 32'h0);
    read_check("post_rst_ctrl", 4'h8, 32'h0);
    send_frame(8'h5A, 1'b1);
    read_check("post_rst_frame", 4'h4, 32'h0000_0101);
    read_rxdata();
    @(negedge clk);
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
